if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the pipeline CPU. Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. The IF/ID register drives the opcode/funct bits into the decoder. The block accepts stalls from the hazard unit and jump redirects from the decoder's `j` output in ID, squashing wrong-path fetches.

## Interface

Parameters:
- `PC_W`, 32, PC and address width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold IF/ID and PC.
- `jump`  in  1  decoder `j` for the instruction currently in ID.
- `jump_target`  in  PC_W  redirect address; valid when `jump`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address; word aligned.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.
- `ifid_pc`  out  PC_W  PC of the IF/ID instruction.
- `ifid_instr`  out  32  instruction; [31:26] opcode and [5:0] funct feed the decoder.

## Operation

- State machine with three states:
  - FETCH (reset state): `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: fetched word buffered, waiting for `stall` to drop; `imem_req`=0.
  - DISCARD: wrong-path fetch still outstanding; its data is dropped.
- FETCH, `imem_ack`=1, `stall`=0, no jump:
  - IF/ID ← {1, `pc`, `imem_rdata`}.
  - `pc` ← `pc`+4.
  - Stay in FETCH.
- FETCH, `imem_ack`=1, `stall`=1:
  - Word and `pc` go to the skid buffer; go to HOLD.
  - IF/ID is unchanged.
- HOLD, `stall`=0:
  - IF/ID ← buffer; `pc` ← buffered pc+4; go to FETCH.
- `jump` is sampled only when `stall`=0. A jump seen while `stall`=1 is ignored; the ID instruction is held and asserts `jump` again later.
- Jump accepted, in any state:
  - `redirect_pc` ← `jump_target`; IF/ID ← bubble (`ifid_valid`=0) next cycle.
  - In FETCH with `imem_ack`=1: data dropped, `pc` ← `jump_target`, stay in FETCH.
  - In FETCH with `imem_ack`=0: go to DISCARD.
  - In HOLD: buffer dropped, `pc` ← `jump_target`, go to FETCH.
- DISCARD:
  - `imem_req`=1 with the old address, held stable until `imem_ack`.
  - On ack: data dropped, `pc` ← `redirect_pc`, go to FETCH.
- A cycle in FETCH without ack, with `stall`=0 and no jump, writes a bubble into IF/ID.
- `pc` wraps modulo 2^PC_W. `jump_target[1:0]` is ignored; it is forced to 00.

## Timing

- Reset values, held while `rst`=1:
  - `pc`=`RESET_PC`, state=FETCH.
  - `imem_req`=0 (forced low during reset).
  - `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=32'h0000_0000 (nop).
- First request: `imem_req`=1 with `imem_addr`=`RESET_PC` in the first cycle after `rst` falls.
- Handshake:
  - `imem_addr` is stable while `imem_req`=1 and unacked.
  - A same-cycle ack (combinational ROM) is legal.
  - Ack is ignored when `imem_req`=0.
- Latency and throughput:
  - Fetch to IF/ID is 1 cycle after the ack edge.
  - With a zero-wait ROM, throughput is 1 instruction/cycle.
- Jump penalty without delay slot: 1 bubble with a zero-wait ROM; 1 + outstanding wait cycles otherwise.
- Simultaneous `stall` and `jump`: stall wins and the jump is ignored.
- Reset mid-operation (any state) returns to FETCH at `RESET_PC`. Any outstanding ack is ignored during reset.

## Configuration

- `IF_DELAY_SLOT_EN` defined:
  - The fetch following a jump (jump pc+4) is delivered to IF/ID with `ifid_valid`=1.
  - The redirect then takes effect: `pc` ← `jump_target`, and DISCARD is never entered for that fetch.
  - No bubble with a zero-wait ROM.
- `IF_DELAY_SLOT_EN` undefined: the wrong-path fetch is squashed as described in Operation.

## Test plan

- Reset, zero-wait ROM, `RESET_PC`=0 -> `imem_addr` sequence 0,4,8,C; `ifid_pc` 0,4,8 one cycle behind; `ifid_valid`=1 from the 2nd cycle after reset.
- `stall`=1 for 3 cycles, starting with IF/ID=pc 8 -> IF/ID holds pc 8. Word at C is buffered with `imem_req`=0. After release, IF/ID=C then 10, with no skipped or duplicated word.
- `jump`=1, `jump_target`=0x100 while fetching 0x14, zero-wait ROM -> one bubble, then `ifid_pc`=0x100. With `IF_DELAY_SLOT_EN`: `ifid_pc`=0x14 (valid), then 0x100.
- 2-wait-state ROM, jump during a pending fetch of 0x20 -> `imem_addr` holds 0x20 until ack; data dropped; next request is 0x200; IF/ID is bubbles until 0x200 arrives.
- `stall` and `jump` asserted together for 1 cycle -> jump ignored, `pc` unchanged. Jump repeated with `stall`=0 -> redirect taken.
- `rst` pulsed during DISCARD -> next cycle `imem_addr`=`RESET_PC`, `ifid_valid`=0, late ack ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// ---------------------------------------------------------------------------
// Instruction-fetch stage. Holds the PC, fetches one word per request from
// instruction memory and loads the IF/ID pipeline register that feeds the
// decoder. It honours stalls from the hazard unit and jump redirects from
// the decoder, squashing wrong-path fetches.
//
// Optional feature macro: IF_DELAY_SLOT_EN
//   defined   : the fetch after a jump (jump pc+4) is delivered as a valid
//               delay-slot instruction, then the redirect takes effect.
//   undefined : the wrong-path fetch is squashed (IF/ID gets a bubble).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall             hold IF/ID and PC (hazard unit)
//   jump, jump_target redirect request from ID; target bits [1:0] ignored
//   imem_req/addr     fetch request and word-aligned address
//   imem_ack/rdata    fetch completion and instruction word
//   ifid_valid/pc/instr  IF/ID register (valid=0 means bubble)
//   dbg_state         current FSM state (FETCH=0, HOLD=1, DISCARD=2)
//
// Handshake: a fetch is issued while imem_req=1 and completes on the rising
// edge where imem_req=1 and imem_ack=1 (a same-cycle ack is legal). While
// imem_req=1 and unacked, imem_addr is held stable. imem_ack is ignored when
// imem_req=0, including throughout reset.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [PC_W-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redir_q, redir_d;
  logic [PC_W-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
`ifdef IF_DELAY_SLOT_EN
  // A jump was accepted while its delay-slot fetch was still outstanding.
  logic            slot_q, slot_d;
`endif

  logic            jump_acc;
  logic            ack_ok;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] seq_pc;

  // Stall has priority: a jump seen under stall is re-asserted later by ID.
  assign jump_acc = jump && !stall;
  assign ack_ok   = imem_req && imem_ack;
  // Masking keeps the target word aligned.
  assign tgt      = jump_target & ~PC_W'(3);

  // Address following a completed fetch: pc+4, or the pending redirect once
  // a delay slot has been fetched.
`ifdef IF_DELAY_SLOT_EN
  assign seq_pc = slot_q ? redir_q : pc_q + PC_W'(4);
`else
  assign seq_pc = pc_q + PC_W'(4);
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
`ifdef IF_DELAY_SLOT_EN
    slot_d       = slot_q;
`endif

    unique case (state_q)
      FETCH: begin
        if (jump_acc) begin
          redir_d = tgt;
`ifdef IF_DELAY_SLOT_EN
          if (ack_ok) begin
            // This fetch is the delay slot: deliver it, then redirect.
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            pc_d         = tgt;
            slot_d       = 1'b0;
          end else begin
            ifid_valid_d = 1'b0;
            slot_d       = 1'b1;
          end
`else
          ifid_valid_d = 1'b0;
          if (ack_ok) pc_d = tgt;
          else        state_d = DISCARD;
`endif
        end else if (stall) begin
          if (ack_ok) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
            pc_d        = seq_pc;
            state_d     = HOLD;
`ifdef IF_DELAY_SLOT_EN
            slot_d      = 1'b0;
`endif
          end
        end else if (ack_ok) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          pc_d         = seq_pc;
`ifdef IF_DELAY_SLOT_EN
          slot_d       = 1'b0;
`endif
        end else begin
          ifid_valid_d = 1'b0;
        end
      end

      HOLD: begin
        // pc already points past the buffered word (set on entry).
        if (jump_acc) begin
          redir_d = tgt;
          pc_d    = tgt;
          state_d = FETCH;
`ifdef IF_DELAY_SLOT_EN
          // The buffered word is the delay slot of the jump.
          ifid_valid_d = 1'b1;
          ifid_pc_d    = buf_pc_q;
          ifid_instr_d = buf_instr_q;
`else
          ifid_valid_d = 1'b0;
`endif
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = buf_pc_q;
          ifid_instr_d = buf_instr_q;
          state_d      = FETCH;
        end
      end

      DISCARD: begin
        if (jump_acc) begin
          redir_d      = tgt;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
        // Wrong-path word is dropped on arrival.
        if (ack_ok) begin
          pc_d    = jump_acc ? tgt : redir_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_q      <= RESET_PC;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
`ifdef IF_DELAY_SLOT_EN
      slot_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
`ifdef IF_DELAY_SLOT_EN
      slot_q       <= slot_d;
`endif
    end
  end

  // In DISCARD pc_q still holds the wrong-path address, keeping it stable.
  assign imem_req   = !rst && (state_q != HOLD);
  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam int PC_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            stall = 1'b0;
  logic            jump = 1'b0;
  logic [PC_W-1:0] jump_target = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic [1:0]      dbg_state;

  if_fetch_stage #(.PC_W(PC_W), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .dbg_state(dbg_state)
  );

  // ---------------- instruction memory model ----------------
  int   ws = 0;            // wait states before ack
  int   wcnt = 0;
  logic force_ack = 1'b0;  // stray ack injection

  function automatic logic [31:0] rom(input logic [PC_W-1:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  assign imem_rdata = rom(imem_addr);
  assign imem_ack   = force_ack | (imem_req && (wcnt >= ws));

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic push_exp(input logic [PC_W-1:0] pc);
    exp_q.push_back({pc, rom(pc)});
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  // A newly loaded valid IF/ID entry (edge not stalled) is popped/compared.
  task automatic tick();
    logic st;
    logic [63:0] e;
    st = stall;
    @(posedge clk);
    #1;
    if (!st && ifid_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected queue empty", ifid_pc, ifid_instr);
      end else begin
        e = exp_q.pop_front();
        if ({ifid_pc, ifid_instr} !== e) begin
          failures++;
          $display("FAIL sb_ifid: got pc=%h instr=%h, expected pc=%h instr=%h",
                   ifid_pc, ifid_instr, e[63:32], e[31:0]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h expected 0", ifid_pc); end
    checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h expected 0", ifid_instr); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin failures++; $display("FAIL first_req: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    tick();
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL stream_a4: got %h expected 4", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stream_a8: got %h expected 8", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'hC || ifid_pc !== 32'h8)
      begin failures++; $display("FAIL stream_aC: got addr=%h ifid_pc=%h expected C/8", imem_addr, ifid_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    push_exp(32'hC); push_exp(32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h8 || ifid_valid !== 1'b1)
        begin failures++; $display("FAIL stall_hold%0d: got req=%b pc=%h v=%b expected 0/8/1", i, imem_req, ifid_pc, ifid_valid); end
    end
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL stall_state: got %0d expected 1", dbg_state); end
    stall = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'hC) begin failures++; $display("FAIL stall_rel: got %h expected C", ifid_pc); end
    tick();
    checks++; if (ifid_pc !== 32'h10 || imem_addr !== 32'h14)
      begin failures++; $display("FAIL stall_next: got pc=%h addr=%h expected 10/14", ifid_pc, imem_addr); end
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_target = 32'h100;
`ifdef IF_DELAY_SLOT_EN
    push_exp(32'h14);
`endif
    push_exp(32'h100); push_exp(32'h104);
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jump_addr: got %h expected 100", imem_addr); end
`ifdef IF_DELAY_SLOT_EN
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h14)
      begin failures++; $display("FAIL jump_slot: got v=%b pc=%h expected 1/14", ifid_valid, ifid_pc); end
`else
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble: got %b expected 0", ifid_valid); end
`endif
    tick();
    checks++; if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1)
      begin failures++; $display("FAIL jump_tgt: got pc=%h v=%b expected 100/1", ifid_pc, ifid_valid); end
    tick();
    checks++; if (imem_addr !== 32'h108) begin failures++; $display("FAIL jump_seq: got %h expected 108", imem_addr); end
  endtask

  task automatic test_wait_jump();
    ws = 2;
    jump = 1'b1; jump_target = 32'h200;
`ifdef IF_DELAY_SLOT_EN
    push_exp(32'h108);
`endif
    push_exp(32'h200);
    tick();
    jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108 || ifid_valid !== 1'b0)
      begin failures++; $display("FAIL wj_pend1: got req=%b addr=%h v=%b expected 1/108/0", imem_req, imem_addr, ifid_valid); end
`ifndef IF_DELAY_SLOT_EN
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL wj_discard: got %0d expected 2", dbg_state); end
`endif
    tick();
    checks++; if (imem_addr !== 32'h108 || ifid_valid !== 1'b0)
      begin failures++; $display("FAIL wj_pend2: got addr=%h v=%b expected 108/0", imem_addr, ifid_valid); end
    tick();
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL wj_redir: got %h expected 200", imem_addr); end
`ifdef IF_DELAY_SLOT_EN
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h108)
      begin failures++; $display("FAIL wj_slot: got v=%b pc=%h expected 1/108", ifid_valid, ifid_pc); end
`else
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL wj_drop: got %b expected 0", ifid_valid); end
`endif
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0)
        begin failures++; $display("FAIL wj_wait%0d: got addr=%h v=%b expected 200/0", i, imem_addr, ifid_valid); end
    end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200)
      begin failures++; $display("FAIL wj_tgt: got v=%b pc=%h expected 1/200", ifid_valid, ifid_pc); end
    ws = 0;
  endtask

  task automatic test_stall_jump();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h200)
      begin failures++; $display("FAIL sj_ignored: got req=%b pc=%h expected 0/200", imem_req, ifid_pc); end
    // Repeat the jump without stall; low target bits must be ignored.
    stall = 1'b0; jump_target = 32'h302;
`ifdef IF_DELAY_SLOT_EN
    push_exp(32'h204);
`endif
    push_exp(32'h300);
    tick();
    jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300)
      begin failures++; $display("FAIL sj_redir: got req=%b addr=%h expected 1/300", imem_req, imem_addr); end
`ifdef IF_DELAY_SLOT_EN
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h204)
      begin failures++; $display("FAIL sj_slot: got v=%b pc=%h expected 1/204", ifid_valid, ifid_pc); end
`else
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL sj_bubble: got %b expected 0", ifid_valid); end
`endif
    tick();
    checks++; if (ifid_pc !== 32'h300 || imem_addr !== 32'h304)
      begin failures++; $display("FAIL sj_tgt: got pc=%h addr=%h expected 300/304", ifid_pc, imem_addr); end
  endtask

  task automatic test_rst_discard();
    ws = 2;
    jump = 1'b1; jump_target = 32'h400;
    tick();
    jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304)
      begin failures++; $display("FAIL rd_pend: got req=%b addr=%h expected 1/304", imem_req, imem_addr); end
    rst = 1'b1; force_ack = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 32'h0 || dbg_state !== 2'd0)
      begin failures++; $display("FAIL rd_reset: got req=%b v=%b addr=%h st=%0d expected 0/0/0/0", imem_req, ifid_valid, imem_addr, dbg_state); end
    rst = 1'b0; force_ack = 1'b0;
    push_exp(32'h0);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin failures++; $display("FAIL rd_req: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h0)
        begin failures++; $display("FAIL rd_wait%0d: got v=%b addr=%h expected 0/0", i, ifid_valid, imem_addr); end
    end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0)
      begin failures++; $display("FAIL rd_first: got v=%b pc=%h expected 1/0", ifid_valid, ifid_pc); end
    ws = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_wait_jump();
    test_stall_jump();
    test_rst_discard();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
